// File: rtl/fp_unit_pkg.sv
// Shared encodings for the FP unit sequencer: op codes, FSM states, request payload.
package fp_unit_pkg;

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned OP_W   = 4;
   localparam int unsigned XLEN   = 32;
   localparam int unsigned RES_W  = 64;
   localparam int unsigned RD_W   = 5;

   localparam logic [OP_W-1:0] FPU_OP_ADDSUB = 4'b0000;
   localparam logic [OP_W-1:0] FPU_OP_MUL    = 4'b0001;
   localparam logic [OP_W-1:0] FPU_OP_DIV    = 4'b0010;
   localparam logic [OP_W-1:0] FPU_OP_SQRT   = 4'b0011;
   localparam logic [OP_W-1:0] FPU_OP_CMP    = 4'b0100;
   localparam logic [OP_W-1:0] FPU_OP_SGNJ   = 4'b0101;
   localparam logic [OP_W-1:0] FPU_OP_CVT    = 4'b0110;
   localparam logic [OP_W-1:0] FPU_OP_MV     = 4'b0111;

   typedef enum logic [1:0] {
      SEQ_IDLE = 2'd0,
      SEQ_EXEC = 2'd1,
      SEQ_WB   = 2'd2
   } seq_state_t;

   typedef struct packed {
      logic [OP_W-1:0] op;
      logic [1:0]      fmt;
      logic            addsub;
      logic [2:0]      ctrl;
      logic [XLEN-1:0] rs1;
      logic [XLEN-1:0] rs2;
      logic [RD_W-1:0] rd;
   } fpu_req_t;

endpackage

// File: rtl/fp_op_lat_decode.sv
// Op -> execute counter load value (latency - 1) and integer-destination flag.
module fp_op_lat_decode
   import fp_unit_pkg::*;
#(
   parameter int unsigned ADDSUB_LAT = 2,
   parameter int unsigned MUL_LAT    = 3,
   parameter int unsigned DIV_LAT    = 8,
   parameter int unsigned MISC_LAT   = 1
) (
   input  logic [OP_W-1:0]  op,
   output logic [CNT_W-1:0] lat_load,
   output logic             int_dst
);

   // Latency lookup; unsupported ops fall into the misc class.
   always_comb begin
      lat_load = CNT_W'(MISC_LAT - 1);
      int_dst  = (op == FPU_OP_CMP) || (op == FPU_OP_CVT);
      case (op)
         FPU_OP_ADDSUB: lat_load = CNT_W'(ADDSUB_LAT - 1);
         FPU_OP_MUL:    lat_load = CNT_W'(MUL_LAT - 1);
         FPU_OP_DIV:    lat_load = CNT_W'(DIV_LAT - 1);
         default:       lat_load = CNT_W'(MISC_LAT - 1);
      endcase
   end

endmodule

// File: rtl/fp_unit_sequencer.sv
// Issue/writeback controller around the combinational FP unit.
// Holds operands stable for an op-dependent latency, then presents the result
// on a valid/ready writeback port. Define FPU_SEQ_FWD_EN to allow a new accept
// on the same edge as the writeback handshake.
module fp_unit_sequencer
   import fp_unit_pkg::*;
#(
   parameter int unsigned ADDSUB_LAT = 2,
   parameter int unsigned MUL_LAT    = 3,
   parameter int unsigned DIV_LAT    = 8,
   parameter int unsigned MISC_LAT   = 1
) (
   input  logic              in_clk,
   input  logic              in_rst_n,
   input  logic              in_valid,
   output logic              out_ready,
   input  logic [3:0]        in_FPU_Op,
   input  logic [1:0]        in_fmt,
   input  logic              in_addsub_ctrl,
   input  logic [2:0]        in_ctrl_minmax_sgnj_cmp,
   input  logic [31:0]       in_rs1,
   input  logic [31:0]       in_rs2,
   input  logic [4:0]        in_rd,
   input  logic              in_flush,
   output logic [31:0]       out_fpu_rs1,
   output logic [31:0]       out_fpu_rs2,
   output logic [3:0]        out_fpu_op,
   output logic [1:0]        out_fmt,
   output logic              out_addsub_ctrl,
   output logic [2:0]        out_ctrl,
   input  logic [63:0]       in_fpu_data,
   output logic              out_wb_valid,
   input  logic              in_wb_ready,
   output logic [63:0]       out_wb_data,
   output logic [4:0]        out_wb_rd,
   output logic              out_wb_int,
   output logic              out_busy
);

   seq_state_t       state, state_n;
   fpu_req_t         req;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] lat_load;
   logic             int_dst;
   logic             int_pend;
   logic             accept;
   logic             capture;

   fp_op_lat_decode #(
      .ADDSUB_LAT (ADDSUB_LAT),
      .MUL_LAT    (MUL_LAT),
      .DIV_LAT    (DIV_LAT),
      .MISC_LAT   (MISC_LAT)
   ) u_lat_decode (
      .op       (in_FPU_Op),
      .lat_load (lat_load),
      .int_dst  (int_dst)
   );

   // Next-state, request acceptance and result capture strobe.
   always_comb begin
      state_n   = state;
      out_ready = 1'b0;
      capture   = 1'b0;
      accept    = 1'b0;
      case (state)
         SEQ_IDLE: out_ready = ~in_flush;
         SEQ_EXEC: capture   = (cnt == '0) & ~in_flush;
         SEQ_WB: begin
`ifdef FPU_SEQ_FWD_EN
            out_ready = in_wb_ready & ~in_flush;
`endif
         end
         default: ;
      endcase
      accept = in_valid & out_ready;
      case (state)
         SEQ_IDLE: if (accept) state_n = SEQ_EXEC;
         SEQ_EXEC: if (cnt == '0) state_n = SEQ_WB;
         SEQ_WB:   if (in_wb_ready) state_n = accept ? SEQ_EXEC : SEQ_IDLE;
         default:  state_n = SEQ_IDLE;
      endcase
      if (in_flush) state_n = SEQ_IDLE;
   end

   // State register plus registered status decoded from the next state.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state        <= SEQ_IDLE;
         out_wb_valid <= 1'b0;
         out_busy     <= 1'b0;
      end else begin
         state        <= state_n;
         out_wb_valid <= (state_n == SEQ_WB);
         out_busy     <= (state_n != SEQ_IDLE);
      end
   end

   // Request latch, execute counter and result capture.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         req         <= '0;
         cnt         <= '0;
         int_pend    <= 1'b0;
         out_wb_data <= '0;
         out_wb_int  <= 1'b0;
      end else begin
         if (accept) begin
            req.op     <= in_FPU_Op;
            req.fmt    <= in_fmt;
            req.addsub <= in_addsub_ctrl;
            req.ctrl   <= in_ctrl_minmax_sgnj_cmp;
            req.rs1    <= in_rs1;
            req.rs2    <= in_rs2;
            req.rd     <= in_rd;
            cnt        <= lat_load;
            int_pend   <= int_dst;
         end else if ((state == SEQ_EXEC) && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
         end
         // Unsupported ops (top bit set) always return zero.
         if (capture) begin
            out_wb_data <= req.op[3] ? '0 : in_fpu_data;
            out_wb_int  <= int_pend;
         end
      end
   end

   assign out_fpu_rs1     = req.rs1;
   assign out_fpu_rs2     = req.rs2;
   assign out_fpu_op      = req.op;
   assign out_fmt         = req.fmt;
   assign out_addsub_ctrl = req.addsub;
   assign out_ctrl        = req.ctrl;
   assign out_wb_rd       = req.rd;

endmodule

// File: tb/tb_fp_unit_sequencer.sv
// Self-checking bench for fp_unit_sequencer: timestamp-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_fp_unit_sequencer;

   localparam int unsigned ADDSUB_LAT = 2;
   localparam int unsigned MUL_LAT    = 3;
   localparam int unsigned DIV_LAT    = 8;
   localparam int unsigned MISC_LAT   = 1;
`ifdef FPU_SEQ_FWD_EN
   localparam int B2B_SPACING = 3;
`else
   localparam int B2B_SPACING = 4;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready;
   logic [3:0]  in_op = 4'd0;
   logic [1:0]  in_fmt = 2'd0;
   logic        in_addsub = 1'b0;
   logic [2:0]  in_ctrl = 3'd0;
   logic [31:0] in_rs1 = 32'd0;
   logic [31:0] in_rs2 = 32'd0;
   logic [4:0]  in_rd = 5'd0;
   logic        in_flush = 1'b0;
   logic [31:0] out_fpu_rs1, out_fpu_rs2;
   logic [3:0]  out_fpu_op;
   logic [1:0]  out_fmt;
   logic        out_addsub_ctrl;
   logic [2:0]  out_ctrl;
   logic [63:0] in_fpu_data = 64'd0;
   logic        out_wb_valid;
   logic        in_wb_ready = 1'b1;
   logic [63:0] out_wb_data;
   logic [4:0]  out_wb_rd;
   logic        out_wb_int;
   logic        out_busy;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fp_unit_sequencer #(
      .ADDSUB_LAT (ADDSUB_LAT), .MUL_LAT (MUL_LAT),
      .DIV_LAT (DIV_LAT), .MISC_LAT (MISC_LAT)
   ) dut (
      .in_clk (clk), .in_rst_n (rst_n), .in_valid (in_valid), .out_ready (out_ready),
      .in_FPU_Op (in_op), .in_fmt (in_fmt), .in_addsub_ctrl (in_addsub),
      .in_ctrl_minmax_sgnj_cmp (in_ctrl), .in_rs1 (in_rs1), .in_rs2 (in_rs2),
      .in_rd (in_rd), .in_flush (in_flush), .out_fpu_rs1 (out_fpu_rs1),
      .out_fpu_rs2 (out_fpu_rs2), .out_fpu_op (out_fpu_op), .out_fmt (out_fmt),
      .out_addsub_ctrl (out_addsub_ctrl), .out_ctrl (out_ctrl),
      .in_fpu_data (in_fpu_data), .out_wb_valid (out_wb_valid),
      .in_wb_ready (in_wb_ready), .out_wb_data (out_wb_data), .out_wb_rd (out_wb_rd),
      .out_wb_int (out_wb_int), .out_busy (out_busy)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
   endtask

   // ---------------- reference model (timestamps, not states) ----------------
   int          m_edge = 0;
   bit          m_inflight = 0;
   bit          m_wbp = 0;
   int          m_done = 0;
   logic [3:0]  m_op = 0;
   logic [1:0]  m_fmt = 0;
   logic        m_as = 0;
   logic [2:0]  m_ctrl = 0;
   logic [31:0] m_rs1 = 0, m_rs2 = 0;
   logic [4:0]  m_rd = 0;
   logic [63:0] m_data = 0;
   logic        m_int = 0;

   function automatic int lat_of(input logic [3:0] op);
      case (op)
         4'd0:    return int'(ADDSUB_LAT);
         4'd1:    return int'(MUL_LAT);
         4'd2:    return int'(DIV_LAT);
         default: return int'(MISC_LAT);
      endcase
   endfunction

   function automatic bit m_ready();
      if (!m_inflight && !m_wbp) return !in_flush;
`ifdef FPU_SEQ_FWD_EN
      if (m_wbp) return in_wb_ready && !in_flush;
`endif
      return 1'b0;
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_inflight = 0; m_wbp = 0; m_op = 0; m_fmt = 0; m_as = 0; m_ctrl = 0;
            m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_data = 0; m_int = 0;
         end else begin
            bit acc;
            m_edge++;
            acc = in_valid && m_ready();
            if (in_flush) begin
               m_inflight = 0;
               m_wbp = 0;
            end else begin
               if (m_wbp && in_wb_ready) m_wbp = 0;
               if (m_inflight && m_edge == m_done) begin
                  m_inflight = 0;
                  m_wbp = 1;
                  m_data = (m_op >= 4'd8) ? 64'd0 : in_fpu_data;
                  m_int = (m_op == 4'd4) || (m_op == 4'd6);
               end
            end
            if (acc) begin
               m_op = in_op; m_fmt = in_fmt; m_as = in_addsub; m_ctrl = in_ctrl;
               m_rs1 = in_rs1; m_rs2 = in_rs2; m_rd = in_rd;
               m_inflight = 1;
               m_done = m_edge + lat_of(in_op);
            end
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         chk("ready", 64'(out_ready), 64'(m_ready()));
         chk("wb_valid", 64'(out_wb_valid), 64'(m_wbp));
         chk("busy", 64'(out_busy), 64'(m_inflight | m_wbp));
         chk("wb_data", out_wb_data, m_data);
         chk("wb_rd", 64'(out_wb_rd), 64'(m_rd));
         chk("wb_int", 64'(out_wb_int), 64'(m_int));
         chk("fpu_rs1", 64'(out_fpu_rs1), 64'(m_rs1));
         chk("fpu_rs2", 64'(out_fpu_rs2), 64'(m_rs2));
         chk("fpu_ctl", 64'({out_fpu_op, out_fmt, out_addsub_ctrl, out_ctrl}),
             64'({m_op, m_fmt, m_as, m_ctrl}));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [4:0] rd, output int acc_edge);
      bit ok = 0;
      acc_edge = 0;
      in_valid = 1'b1; in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
      in_fmt = 2'd0; in_addsub = 1'b0; in_ctrl = 3'd0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_ready) begin
            ok = 1;
            acc_edge = cyc + 1;
            break;
         end
      end
      tick();
      in_valid = 1'b0;
      if (!ok) timeout_fail("issue");
   endtask

   task automatic wait_valid(input string name, output int v_edge);
      bit ok = 0;
      v_edge = 0;
      for (int i = 0; i < 40; i++) begin
         if (i != 0) @(negedge clk);
         else @(negedge clk);
         if (out_wb_valid) begin
            ok = 1;
            v_edge = cyc;
            break;
         end
      end
      if (!ok) timeout_fail(name);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int a, v;
      int acc_edges[$];

      // Reset state.
      repeat (2) @(negedge clk);
      chk("rst_ready", 64'(out_ready), 64'd1);
      chk("rst_valid", 64'(out_wb_valid), 64'd0);
      chk("rst_busy", 64'(out_busy), 64'd0);
      chk("rst_data", out_wb_data, 64'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // ADD: latency 3, result zero-extended stub value.
      in_wb_ready = 1'b1;
      in_fpu_data = 64'h0000_0000_4040_0000;
      issue(4'b0000, 32'h3F80_0000, 32'h4000_0000, 5'd3, a);
      wait_valid("add_wait", v);
      chk("add_lat", 64'(v - a + 1), 64'd3);
      chk("add_data", out_wb_data, 64'h0000_0000_4040_0000);
      chk("add_int", 64'(out_wb_int), 64'd0);
      chk("add_rs1", 64'(out_fpu_rs1), 64'h3F80_0000);
      repeat (3) tick();

      // DIV with a 5-cycle writeback stall.
      in_wb_ready = 1'b0;
      in_fpu_data = 64'h1234_5678_9ABC_DEF0;
      issue(4'b0010, 32'h4120_0000, 32'h4000_0000, 5'd9, a);
      wait_valid("div_wait", v);
      chk("div_lat", 64'(v - a + 1), 64'd9);
      in_fpu_data = 64'h0BAD_0BAD_0BAD_0BAD;
      repeat (5) begin
         tick();
         @(negedge clk);
         chk("div_stall_valid", 64'(out_wb_valid), 64'd1);
         chk("div_stall_data", out_wb_data, 64'h1234_5678_9ABC_DEF0);
         chk("div_stall_rd", 64'(out_wb_rd), 64'd9);
      end
      tick();
      in_wb_ready = 1'b1;
      tick();
      @(negedge clk);
      chk("div_idle_busy", 64'(out_busy), 64'd0);
      chk("div_idle_valid", 64'(out_wb_valid), 64'd0);
      tick();

      // CMP: integer destination, latency 2.
      issue(4'b0100, 32'h3F80_0000, 32'h3F80_0000, 5'd7, a);
      wait_valid("cmp_wait", v);
      chk("cmp_lat", 64'(v - a + 1), 64'd2);
      chk("cmp_int", 64'(out_wb_int), 64'd1);
      chk("cmp_rd", 64'(out_wb_rd), 64'd7);
      repeat (3) tick();

      // Flush in the second EXEC cycle of a MUL.
      issue(4'b0001, 32'h4040_0000, 32'h4040_0000, 5'd4, a);
      tick();
      in_flush = 1'b1;
      tick();
      in_flush = 1'b0;
      @(negedge clk);
      chk("flush_ready", 64'(out_ready), 64'd1);
      chk("flush_busy", 64'(out_busy), 64'd0);
      repeat (6) begin
         @(negedge clk);
         chk("flush_no_valid", 64'(out_wb_valid), 64'd0);
      end
      tick();
      issue(4'b0000, 32'h3F80_0000, 32'h3F80_0000, 5'd5, a);
      wait_valid("post_flush_wait", v);
      chk("post_flush_lat", 64'(v - a + 1), 64'd3);
      repeat (3) tick();

      // Back-to-back ADDs with in_valid held high.
      in_valid = 1'b1; in_op = 4'b0000; in_rd = 5'd1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (out_ready) acc_edges.push_back(cyc + 1);
      end
      tick();
      in_valid = 1'b0;
      if (acc_edges.size() < 3) timeout_fail("b2b_accepts");
      else begin
         chk("b2b_gap0", 64'(acc_edges[1] - acc_edges[0]), 64'(B2B_SPACING));
         chk("b2b_gap1", 64'(acc_edges[2] - acc_edges[1]), 64'(B2B_SPACING));
      end
      repeat (6) tick();

      // Asynchronous reset mid-DIV, then an unsupported op returns zero.
      issue(4'b0010, 32'hAAAA_5555, 32'h5555_AAAA, 5'd12, a);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(out_wb_valid), 64'd0);
      chk("arst_busy", 64'(out_busy), 64'd0);
      chk("arst_rs1", 64'(out_fpu_rs1), 64'd0);
      chk("arst_op", 64'(out_fpu_op), 64'd0);
      chk("arst_rd", 64'(out_wb_rd), 64'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      in_fpu_data = 64'hDEAD_BEEF_CAFE_F00D;
      issue(4'b1111, 32'h1, 32'h2, 5'd30, a);
      wait_valid("unsup_wait", v);
      chk("unsup_lat", 64'(v - a + 1), 64'd2);
      chk("unsup_data", out_wb_data, 64'd0);
      repeat (3) tick();

      // Randomized traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         in_valid    = ($urandom_range(0, 99) < 55);
         in_op       = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15))
                                                   : 4'($urandom_range(0, 7));
         in_fmt      = 2'($urandom);
         in_addsub   = 1'($urandom);
         in_ctrl     = 3'($urandom);
         in_rs1      = $urandom;
         in_rs2      = $urandom;
         in_rd       = 5'($urandom);
         in_flush    = ($urandom_range(0, 99) < 3);
         in_wb_ready = ($urandom_range(0, 99) < 70);
         in_fpu_data = {$urandom, $urandom};
         tick();
      end
      in_valid = 1'b0; in_flush = 1'b0; in_wb_ready = 1'b1;
      repeat (20) tick();
      chk("drain_busy", 64'(out_busy), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fp_unit_sequencer.md
# fp_unit_sequencer

Issue/writeback controller wrapped around the combinational floating-point unit. Accepts one FP operation at a time over a valid/ready handshake and registers its operands and controls. It holds them stable on the FP_Unit inputs for an op-dependent number of cycles, then captures the 64-bit result and presents it on a valid/ready writeback port. The unit is thereby multicycle-safe inside the core pipeline, and results are tagged for the FP or integer register file.

## Interface
- ADDSUB_LAT, 2: execute cycles for op 4'b0000 (1..16)
- MUL_LAT, 3: execute cycles for op 4'b0001 (1..16)
- DIV_LAT, 8: execute cycles for op 4'b0010 (1..16)
- MISC_LAT, 1: execute cycles for all other ops (1..16)
- in_clk  in  1  clock, rising edge
- in_rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  request valid
- out_ready  out  1  request accepted when in_valid & out_ready at a rising edge
- in_FPU_Op  in  4  operation select (unit encoding 0000..0111)
- in_fmt  in  2  convert format
- in_addsub_ctrl  in  1  add/sub select
- in_ctrl_minmax_sgnj_cmp  in  3  min/max/sgnj/cmp sub-op
- in_rs1, in_rs2  in  32 each  operands
- in_rd  in  5  destination register index
- in_flush  in  1  synchronous abort, highest priority
- out_fpu_rs1, out_fpu_rs2  out  32 each  registered operands to FP_Unit
- out_fpu_op  out  4; out_fmt  out  2; out_addsub_ctrl  out  1; out_ctrl  out  3  registered controls to FP_Unit
- in_fpu_data  in  64  FP_Unit result
- out_wb_valid  out  1  result valid
- in_wb_ready  in  1  writeback consumer ready
- out_wb_data  out  64  captured result
- out_wb_rd  out  5  destination index
- out_wb_int  out  1  1 = integer regfile (ops 0100, 0110); 0 = FP regfile
- out_busy  out  1  state != IDLE

## Operation
- States: IDLE, EXEC, WB. Reset -> IDLE. All registered outputs reset to 0. out_ready reads 1 in reset (combinational from IDLE) but nothing is latched until in_rst_n deasserts.
- IDLE: out_ready = ~in_flush. On accept, latch operands/controls/rd and load cnt = LAT(op) - 1, then go to EXEC.
- LAT(op): 0000 -> ADDSUB_LAT; 0001 -> MUL_LAT; 0010 -> DIV_LAT; else MISC_LAT. Ops 1000..1111 are unsupported. They are accepted and complete with MISC_LAT; the unit returns 0.
- EXEC: cnt decrements each cycle. At cnt == 0, capture in_fpu_data into out_wb_data, set out_wb_int, and go to WB. cnt is 4 bits and never wraps below 0.
- WB: out_wb_valid = 1. Data/rd/int hold stable until in_wb_ready. On handshake, go to IDLE (see Configuration).
- in_flush in any state: next state IDLE, out_wb_valid 0 next cycle, and the pending result is discarded. A request presented in the flush cycle is not accepted.
- FP_Unit-facing outputs keep their last value in IDLE. They change only on accept.

## Timing
- Accept edge t0. EXEC occupies cycles t0+1 .. t0+LAT. The result is sampled at the edge ending cycle t0+LAT. out_wb_valid is high from cycle t0+LAT+1.
- Minimum issue-to-writeback: LAT+1 cycles. The writeback port sustains stalls indefinitely.
- Throughput without FWD: one op per LAT+2 cycles, given in_wb_ready = 1.
- Asynchronous reset mid-EXEC or mid-WB: immediate IDLE, outputs 0, and the op is lost.

## Configuration
- FPU_SEQ_FWD_EN defined: in WB, out_ready = in_wb_ready & ~in_flush. A same-edge writeback handshake plus new accept goes directly to EXEC, so throughput is one op per LAT+1 cycles.
- Undefined: out_ready = 1 only in IDLE, which costs one idle cycle between ops.

## Structure
- Shared package fp_unit_pkg holds:
  - op encodings FPU_OP_ADDSUB..FPU_OP_MV (4'b0000..4'b0111)
  - state encodings SEQ_IDLE/SEQ_EXEC/SEQ_WB
  - counter width constant (4)
- One sub-module, fp_op_lat_decode: combinational op -> 4-bit load value (LAT-1) and int-destination flag, parameterised by the four latencies.

## Test plan
- ADD, op 0000, rs1 = 0x3F800000, rs2 = 0x40000000, stub in_fpu_data = 0x40400000, defaults -> out_wb_valid rises 3 cycles after accept; out_wb_data = 0x0000_0000_4040_0000, out_wb_int = 0.
- DIV, op 0010, in_wb_ready held 0 for 5 cycles -> out_wb_valid rises at accept+9 and data/rd hold stable through the stall; IDLE one cycle after in_wb_ready.
- CMP, op 0100, rd = 7 -> out_wb_int = 1, out_wb_rd = 7, latency 2.
- in_flush asserted in the 2nd EXEC cycle of a MUL -> no out_wb_valid; out_ready = 1 the next cycle; the following ADD completes normally.
- Back-to-back ADDs, in_valid held high, in_wb_ready = 1 -> accepts every 3 cycles with FPU_SEQ_FWD_EN, every 4 without.
- Reset asserted mid-DIV -> all outputs 0 immediately; after release, op 1111 completes with out_wb_data = 0 in 2 cycles.
